script_executor: RTL and testbench

- Reader side of the script path. Walks the instruction store through the pc/script interface after a script has been loaded over UART.
- Decodes each 16-bit instruction and issues command bytes to the UART transmit port (io_dataIn_bits / io_dataIn_ready).
- Waits on millisecond ticks or feedback bits from the receive-side decoder.
- Sits between the script memory, the clock divider's millisecond tick, the feedback decoder and the UART, in parallel with the manual send path. The top-level mux selects the transmit source.

---
 rtl/script_executor.sv | 172 +++++++++++++++++
 tb/tb_script_executor.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/script_executor.sv
// Script executor: fetches 16-bit instructions from the script store, issues UART command bytes,
// and waits on ms ticks or feedback bits. Optional WAIT_UNTIL timeout: SCRIPT_WAIT_TIMEOUT_EN.
module script_executor #(
  parameter int unsigned PC_W          = 8,
  parameter int unsigned WAIT_W        = 8,
  parameter int unsigned FB_TIMEOUT_MS = 1000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            run,
  input  logic            script_mode,
  output logic [PC_W-1:0] pc,
  input  logic [15:0]     script,
  input  logic            ms_tick,
  input  logic [7:0]      feedback,
  output logic [7:0]      tx_bits,
  output logic            tx_valid,
  input  logic            tx_done,
  output logic            busy,
  output logic            halted,
  output logic            error
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, SEND, WAIT_MS, WAIT_FB, HALT
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [2:0]        fb_sel;

  logic [2:0] op;
  logic [2:0] sel;
  logic [7:0] imm;
  logic       unused_bits;

  assign op          = script[15:13];
  assign sel         = script[10:8];
  assign imm         = script[7:0];
  assign unused_bits = ^script[12:11];

  assign busy   = (state != IDLE) && (state != HALT);
  assign halted = (state == HALT);

`ifdef SCRIPT_WAIT_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(FB_TIMEOUT_MS + 1);
  logic [TO_W-1:0] fb_cnt;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= '0;
      tx_bits  <= '0;
      tx_valid <= 1'b0;
      error    <= 1'b0;
      wait_cnt <= '0;
      fb_sel   <= '0;
`ifdef SCRIPT_WAIT_TIMEOUT_EN
      fb_cnt   <= '0;
`endif
    end else if (script_mode) begin
      // Loading a new script aborts everything, including a byte in flight.
      state    <= IDLE;
      pc       <= '0;
      tx_valid <= 1'b0;
    end else if (!run && (state == FETCH || state == DECODE ||
                          state == WAIT_MS || state == WAIT_FB)) begin
      state <= IDLE;
      pc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state <= FETCH;
            pc    <= '0;
            error <= 1'b0;
          end
        end
        FETCH: state <= DECODE;
        DECODE: begin
          case (op)
            3'b000: begin
              tx_bits  <= imm;
              tx_valid <= 1'b1;
              state    <= SEND;
            end
            3'b001: begin
              if (imm == 8'd0) begin
                pc    <= pc + PC_W'(1);
                state <= FETCH;
              end else begin
                wait_cnt <= WAIT_W'(imm);
                state    <= WAIT_MS;
              end
            end
            3'b010: begin
              pc    <= PC_W'(imm);
              state <= FETCH;
            end
            3'b011: begin
              pc    <= feedback[sel] ? PC_W'(imm) : pc + PC_W'(1);
              state <= FETCH;
            end
            3'b100: begin
              fb_sel <= sel;
`ifdef SCRIPT_WAIT_TIMEOUT_EN
              fb_cnt <= '0;
`endif
              state  <= WAIT_FB;
            end
            3'b101: begin
              pc    <= pc + PC_W'(1);
              state <= FETCH;
            end
            3'b110: begin
              error <= 1'b1;
              state <= HALT;
            end
            3'b111: state <= HALT;
          endcase
        end
        SEND: begin
          // A stop request lets the current byte finish before returning to IDLE.
          if (tx_done) begin
            tx_valid <= 1'b0;
            if (run) begin
              pc    <= pc + PC_W'(1);
              state <= FETCH;
            end else begin
              pc    <= '0;
              state <= IDLE;
            end
          end
        end
        WAIT_MS: begin
          if (ms_tick) begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
            if (wait_cnt == WAIT_W'(1)) begin
              pc    <= pc + PC_W'(1);
              state <= FETCH;
            end
          end
        end
        WAIT_FB: begin
          if (feedback[fb_sel]) begin
            pc    <= pc + PC_W'(1);
            state <= FETCH;
          end
`ifdef SCRIPT_WAIT_TIMEOUT_EN
          else if (ms_tick) begin
            if (fb_cnt == TO_W'(FB_TIMEOUT_MS - 1)) begin
              error <= 1'b1;
              state <= HALT;
            end else begin
              fb_cnt <= fb_cnt + TO_W'(1);
            end
          end
`endif
        end
        HALT: begin
          if (!run) begin
            pc    <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_script_executor.sv
// Bench for script_executor: table of short scripts with a byte scoreboard, plus timing sequences.
module tb_script_executor;

  logic        clock = 1'b0;
  logic        reset;
  logic        run;
  logic        script_mode;
  logic [7:0]  pc;
  logic [15:0] script;
  logic        ms_tick;
  logic [7:0]  feedback;
  logic [7:0]  tx_bits;
  logic        tx_valid;
  logic        tx_done;
  logic        busy;
  logic        halted;
  logic        error;

  script_executor #(.PC_W(8), .WAIT_W(8), .FB_TIMEOUT_MS(4)) dut (
    .clock(clock), .reset(reset), .run(run), .script_mode(script_mode),
    .pc(pc), .script(script), .ms_tick(ms_tick), .feedback(feedback),
    .tx_bits(tx_bits), .tx_valid(tx_valid), .tx_done(tx_done),
    .busy(busy), .halted(halted), .error(error)
  );

  always #5 clock = ~clock;

  logic [15:0] mem [256];
  always @(posedge clock) script <= mem[pc];

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [$];

  typedef struct {
    logic [15:0] i0, i1, i2, i3;
    logic [7:0]  fb;
    int          nbytes;
    logic [7:0]  b0, b1;
    logic [7:0]  exp_pc;
    logic        exp_err;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_prog(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d);
    for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
    mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
  endtask

  task automatic do_reset();
    run = 1'b0; script_mode = 1'b0; tx_done = 1'b0; ms_tick = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int n, hold, hcount, extra, ticks;
    bit done;
    vec_t v;
    logic [7:0] expb;

    vecs[0] = '{16'h0041, 16'hE000, 16'hE000, 16'hE000, 8'h00, 1, 8'h41, 8'h00, 8'd1, 1'b0};
    vecs[1] = '{16'h6105, 16'h0033, 16'hE000, 16'hE000, 8'h00, 1, 8'h33, 8'h00, 8'd2, 1'b0};
    vecs[2] = '{16'h6105, 16'h0033, 16'hE000, 16'hE000, 8'h02, 0, 8'h00, 8'h00, 8'd5, 1'b0};
    vecs[3] = '{16'hC000, 16'h0033, 16'hE000, 16'hE000, 8'h00, 0, 8'h00, 8'h00, 8'd0, 1'b1};
    vecs[4] = '{16'hA000, 16'h0012, 16'h2000, 16'h0034, 8'h00, 2, 8'h12, 8'h34, 8'd4, 1'b0};
    vecs[5] = '{16'h4003, 16'h0055, 16'hE000, 16'h0066, 8'h00, 1, 8'h66, 8'h00, 8'd4, 1'b0};
    vecs[6] = '{16'h8200, 16'h0011, 16'hE000, 16'hE000, 8'h04, 1, 8'h11, 8'h00, 8'd2, 1'b0};
    vecs[7] = '{16'h2002, 16'h0077, 16'hE000, 16'hE000, 8'h00, 1, 8'h77, 8'h00, 8'd2, 1'b0};
    vecs[8] = '{16'h6707, 16'h0033, 16'hE000, 16'hE000, 8'h80, 0, 8'h00, 8'h00, 8'd7, 1'b0};

    reset = 1'b1; run = 1'b0; script_mode = 1'b0; tx_done = 1'b0;
    ms_tick = 1'b0; feedback = 8'h00;

    // Reset state and the ACTION handshake with a 5-cycle UART.
    load_prog(16'h0041, 16'hE000, 16'hE000, 16'hE000);
    do_reset();
    chk("rst_pc", pc, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_bits", tx_bits, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_error", error, 0);
    run = 1'b1;
    n = 0;
    while (!tx_valid && n < 20) begin @(negedge clock); n++; end
    chk("a_valid_seen", tx_valid, 1);
    hcount = 0;
    for (int c = 0; c < 5; c++) begin
      if (tx_valid && tx_bits == 8'h41) hcount++;
      if (c == 4) tx_done = 1'b1;
      @(negedge clock);
    end
    tx_done = 1'b0;
    chk("a_hold_cycles", hcount, 5);
    chk("a_valid_dropped", tx_valid, 0);
    extra = 0; n = 0;
    while (!halted && n < 20) begin
      @(negedge clock); n++;
      if (tx_valid) extra++;
    end
    chk("a_halted", halted, 1);
    chk("a_halt_pc", pc, 1);
    chk("a_no_second_byte", extra, 0);

    // Table-driven scripts; bytes checked against the scoreboard.
    for (int vi = 0; vi < 9; vi++) begin
      v = vecs[vi];
      load_prog(v.i0, v.i1, v.i2, v.i3);
      feedback = v.fb;
      do_reset();
      sb.delete();
      if (v.nbytes > 0) sb.push_back(v.b0);
      if (v.nbytes > 1) sb.push_back(v.b1);
      run = 1'b1;
      hold = 0; done = 1'b0;
      for (int c = 0; c < 400 && !done; c++) begin
        @(negedge clock);
        tx_done = 1'b0; ms_tick = 1'b0;
        if (halted) done = 1'b1;
        else begin
          if (c % 7 == 6) ms_tick = 1'b1;
          if (tx_valid) begin
            hold++;
            if (hold == 3) begin
              if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL v%0d_tx_extra: got byte %0h expected none", vi, tx_bits);
              end else begin
                expb = sb.pop_front();
                chk($sformatf("v%0d_tx_byte", vi), tx_bits, expb);
              end
              tx_done = 1'b1;
              hold = 0;
            end
          end
        end
      end
      tx_done = 1'b0; ms_tick = 1'b0;
      chk($sformatf("v%0d_halted", vi), halted, 1);
      chk($sformatf("v%0d_pc", vi), pc, v.exp_pc);
      chk($sformatf("v%0d_error", vi), error, v.exp_err);
      chk($sformatf("v%0d_bytes_left", vi), sb.size(), 0);
      run = 1'b0;
      @(negedge clock);
    end
    feedback = 8'h00;

    // WAIT 3: the byte appears only after the third tick.
    load_prog(16'h2003, 16'h0007, 16'hE000, 16'hE000);
    do_reset();
    run = 1'b1;
    repeat (6) @(negedge clock);
    ticks = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      ms_tick = 1'b0;
      if (tx_valid) break;
      if (c % 5 == 0) begin ms_tick = 1'b1; ticks++; end
    end
    ms_tick = 1'b0;
    chk("wait3_valid", tx_valid, 1);
    chk("wait3_ticks", ticks, 3);
    chk("wait3_bits", tx_bits, 8'h07);

    // WAIT 0 behaves as NOP: ACTION reaches SEND 5 cycles after run.
    load_prog(16'h2000, 16'h0007, 16'hE000, 16'hE000);
    do_reset();
    run = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (!tx_valid && n < 20);
    chk("wait0_latency", n, 5);

    // WAIT_UNTIL bit2 stalls until feedback changes.
    load_prog(16'h8200, 16'h0011, 16'hE000, 16'hE000);
    feedback = 8'h00;
    do_reset();
    run = 1'b1;
    extra = 0;
    repeat (20) begin @(negedge clock); if (tx_valid) extra++; end
    chk("wfb_no_tx", extra, 0);
    chk("wfb_busy", busy, 1);
    feedback = 8'h04;
    n = 0;
    while (!tx_valid && n < 10) begin @(negedge clock); n++; end
    chk("wfb_tx_valid", tx_valid, 1);
    chk("wfb_tx_bits", tx_bits, 8'h11);
    feedback = 8'h00;

    // JUMP 255 then NOP at 255 wraps the pc to 0.
    load_prog(16'h40FF, 16'hE000, 16'hE000, 16'hE000);
    mem[255] = 16'hA000;
    do_reset();
    run = 1'b1;
    n = 0;
    while (pc != 8'd255 && n < 20) begin @(negedge clock); n++; end
    chk("jump_pc255", pc, 8'd255);
    n = 0;
    while (pc == 8'd255 && n < 20) begin @(negedge clock); n++; end
    chk("wrap_pc0", pc, 0);
    chk("wrap_no_error", error, 0);

    // script_mode during SEND.
    load_prog(16'h0041, 16'hE000, 16'hE000, 16'hE000);
    do_reset();
    run = 1'b1;
    n = 0;
    while (!tx_valid && n < 20) begin @(negedge clock); n++; end
    chk("sm_send_valid", tx_valid, 1);
    script_mode = 1'b1;
    @(negedge clock);
    chk("sm_send_tx_valid", tx_valid, 0);
    chk("sm_send_busy", busy, 0);
    chk("sm_send_pc", pc, 0);
    script_mode = 1'b0; run = 1'b0;

    // script_mode during WAIT_MS, after a NOP moved pc to 1.
    load_prog(16'hA000, 16'h20FF, 16'hE000, 16'hE000);
    do_reset();
    run = 1'b1;
    repeat (7) @(negedge clock);
    chk("sm_wait_busy_before", busy, 1);
    chk("sm_wait_pc_before", pc, 1);
    script_mode = 1'b1;
    @(negedge clock);
    script_mode = 1'b0; run = 1'b0;
    chk("sm_wait_busy", busy, 0);
    chk("sm_wait_pc", pc, 0);
    chk("sm_wait_tx_valid", tx_valid, 0);

    // WAIT_UNTIL on a bit held low.
    load_prog(16'h8300, 16'h0011, 16'hE000, 16'hE000);
    feedback = 8'h00;
    do_reset();
    run = 1'b1;
    repeat (5) @(negedge clock);
`ifdef SCRIPT_WAIT_TIMEOUT_EN
    for (int t = 0; t < 4; t++) begin
      if (t == 3) chk("to_not_yet", halted, 0);
      ms_tick = 1'b1;
      @(negedge clock);
      ms_tick = 1'b0;
      repeat (4) @(negedge clock);
    end
    chk("to_halted", halted, 1);
    chk("to_error", error, 1);
`else
    for (int t = 0; t < 100; t++) begin
      ms_tick = 1'b1;
      @(negedge clock);
      ms_tick = 1'b0;
      @(negedge clock);
    end
    chk("nto_busy", busy, 1);
    chk("nto_halted", halted, 0);
    chk("nto_error", error, 0);
`endif
    run = 1'b0;
    @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
